// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the memory arbiter: word size, default
// memory latency, FSM state encoding and the round-robin grant helper.
package memory_arbiter_pkg;

    localparam int WORD_SIZE_DEFAULT   = 16;
    localparam int MEM_LATENCY_DEFAULT = 2;
    // Wide enough for the largest legal latency (15).
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Round-robin pick: on a tie, serve whoever was not served last.
    function automatic grant_t pick_grant(input logic i_req, input logic d_req,
                                          input grant_t last);
        if (i_req && d_req)
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        else if (d_req)
            return GRANT_D;
        else
            return GRANT_I;
    endfunction

endpackage

// File: rtl/memory_arbiter_counter.sv
// Loadable down-counter with zero flag; times the memory latency window.
module mem_latency_counter
    import memory_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single
// fixed-latency memory. One access at a time; ties resolved round-robin.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    // instruction port
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_done,
    // data port
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    // memory side
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 busy
);

    // Counter is loaded with LATENCY-1 so BUSY lasts exactly MEM_LATENCY cycles.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    state_t               state, next_state;
    grant_t               last_grant, grant;
    logic                 i_req, d_req, any_req;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic                 lat_write;
    logic [WORD_SIZE-1:0] lat_addr, lat_wdata;

    assign i_req    = i_readM;
    assign d_req    = d_readM | d_writeM;
    assign any_req  = i_req | d_req;
    assign grant    = pick_grant(i_req, d_req, last_grant);
    assign cnt_load = (state == ST_IDLE) && any_req;
    assign cnt_dec  = (state == ST_BUSY_I) || (state == ST_BUSY_D);

    mem_latency_counter #(.W(CNT_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (LOAD_VAL),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state: arbitrate only in IDLE, finish when the latency count expires.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (any_req)
                    next_state = (grant == GRANT_D) ? ST_BUSY_D : ST_BUSY_I;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (cnt_zero)
                    next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Request latch at grant, read-data capture on the final BUSY edge.
    // m_rdata only ever lands in a register, never on an output directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_I;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            i_data     <= '0;
            d_rdata    <= '0;
        end else begin
            if (cnt_load) begin
                last_grant <= grant;
                lat_addr   <= (grant == GRANT_D) ? d_address : i_address;
                // read+write together is treated as a write
                lat_write  <= (grant == GRANT_D) && d_writeM;
                lat_wdata  <= ((grant == GRANT_D) && d_writeM) ? d_wdata : '0;
            end
            if ((state == ST_BUSY_I) && cnt_zero)
                i_data <= m_rdata;
            if ((state == ST_BUSY_D) && cnt_zero && !lat_write)
                d_rdata <= m_rdata;
        end
    end

    // Outputs decoded from state; memory strobes only while BUSY.
    always_comb begin
        busy      = (state != ST_IDLE);
        m_readM   = 1'b0;
        m_writeM  = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            ST_BUSY_I: begin
                m_readM   = 1'b1;
                m_address = lat_addr;
                m_wdata   = lat_wdata;
            end
            ST_BUSY_D: begin
                m_readM   = !lat_write;
                m_writeM  = lat_write;
                m_address = lat_addr;
                m_wdata   = lat_wdata;
            end
            ST_DONE: begin
                i_done = (last_grant == GRANT_I);
                d_done = (last_grant == GRANT_D);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a vector table of single accesses
// plus hand-written sequences for round-robin, reset mid-access and latency.
module tb_memory_arbiter;

    localparam int L0 = 2;

    logic        clk;
    logic        reset;
    logic        i_readM, d_readM, d_writeM;
    logic [15:0] i_address, d_address, d_wdata;

    logic [15:0] i_data_a [3];
    logic [15:0] d_rdata_a [3];
    logic [15:0] m_address_a [3];
    logic [15:0] m_wdata_a [3];
    logic [15:0] m_rdata_a [3];
    logic        i_done_a [3];
    logic        d_done_a [3];
    logic        m_readM_a [3];
    logic        m_writeM_a [3];
    logic        busy_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hABCD : (a ^ 16'h5A5A);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three DUTs (latency 2, 1, 5) sharing stimulus, each with a memory model
    // that only presents valid data in the last cycle of the read window.
    genvar k;
    for (k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 5;
        logic [3:0] rd_cnt = 4'd0;
        always @(posedge clk) rd_cnt <= m_readM_a[k] ? rd_cnt + 4'd1 : 4'd0;
        assign m_rdata_a[k] = (m_readM_a[k] && rd_cnt == 4'(L - 1))
                              ? mem_word(m_address_a[k]) : 16'hDEAD;
        memory_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .i_readM   (i_readM),
            .i_address (i_address),
            .i_data    (i_data_a[k]),
            .i_done    (i_done_a[k]),
            .d_readM   (d_readM),
            .d_writeM  (d_writeM),
            .d_address (d_address),
            .d_wdata   (d_wdata),
            .d_rdata   (d_rdata_a[k]),
            .d_done    (d_done_a[k]),
            .m_readM   (m_readM_a[k]),
            .m_writeM  (m_writeM_a[k]),
            .m_address (m_address_a[k]),
            .m_wdata   (m_wdata_a[k]),
            .m_rdata   (m_rdata_a[k]),
            .busy      (busy_a[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_mrd;
        logic        exp_mwr;
        logic [15:0] exp_mwdata;
        logic [15:0] exp_i_data;
        logic [15:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // is_d rd wr addr     wdata    mrd mwr mwdata   i_data   d_rdata
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABCD, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'h1234, 16'hABCD, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABCD, 16'h5A1A};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0050, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 16'hABCD, 16'h5A1A};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hA5A5, 16'h5A1A};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hA5A5, 16'h5A5A};

        reset = 1'b1;
        i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst busy",     32'(busy_a[0]),      32'h0);
        chk("rst m_readM",  32'(m_readM_a[0]),   32'h0);
        chk("rst m_writeM", 32'(m_writeM_a[0]),  32'h0);
        chk("rst m_address",32'(m_address_a[0]), 32'h0);
        chk("rst m_wdata",  32'(m_wdata_a[0]),   32'h0);
        chk("rst i_done",   32'(i_done_a[0]),    32'h0);
        chk("rst d_done",   32'(d_done_a[0]),    32'h0);
        chk("rst i_data",   32'(i_data_a[0]),    32'h0);
        chk("rst d_rdata",  32'(d_rdata_a[0]),   32'h0);
        reset = 1'b0;

        // Single accesses from IDLE; request dropped right after the grant
        // edge, so each vector also checks that a drop does not abort.
        for (int v = 0; v < 6; v++) begin
            i_readM   = !vecs[v].is_d;
            d_readM   = vecs[v].is_d & vecs[v].rd;
            d_writeM  = vecs[v].is_d & vecs[v].wr;
            i_address = vecs[v].addr;
            d_address = vecs[v].addr;
            d_wdata   = vecs[v].wdata;
            @(posedge clk);
            #1;
            i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
            for (int c = 1; c <= L0 + 1; c++) begin
                @(negedge clk);
                if (c <= L0) begin
                    chk($sformatf("v%0d c%0d m_readM", v, c),   32'(m_readM_a[0]),   32'(vecs[v].exp_mrd));
                    chk($sformatf("v%0d c%0d m_writeM", v, c),  32'(m_writeM_a[0]),  32'(vecs[v].exp_mwr));
                    chk($sformatf("v%0d c%0d m_address", v, c), 32'(m_address_a[0]), 32'(vecs[v].addr));
                    chk($sformatf("v%0d c%0d m_wdata", v, c),   32'(m_wdata_a[0]),   32'(vecs[v].exp_mwdata));
                    chk($sformatf("v%0d c%0d done", v, c),      32'({i_done_a[0], d_done_a[0]}), 32'h0);
                end else begin
                    chk($sformatf("v%0d done m_strobes", v), 32'({m_readM_a[0], m_writeM_a[0]}), 32'h0);
                    chk($sformatf("v%0d i_done", v),  32'(i_done_a[0]),  32'(!vecs[v].is_d));
                    chk($sformatf("v%0d d_done", v),  32'(d_done_a[0]),  32'(vecs[v].is_d));
                    chk($sformatf("v%0d i_data", v),  32'(i_data_a[0]),  32'(vecs[v].exp_i_data));
                    chk($sformatf("v%0d d_rdata", v), 32'(d_rdata_a[0]), 32'(vecs[v].exp_d_rdata));
                end
                chk($sformatf("v%0d c%0d busy", v, c), 32'(busy_a[0]), 32'h1);
            end
            @(negedge clk);
            chk($sformatf("v%0d idle busy", v), 32'(busy_a[0]), 32'h0);
            chk($sformatf("v%0d idle done", v), 32'({i_done_a[0], d_done_a[0]}), 32'h0);
        end

        // Round-robin: both held from reset release -> D, I, D, I, 4 cycles apart.
        reset = 1'b1;
        i_readM = 1'b1; d_readM = 1'b1; d_writeM = 1'b0;
        i_address = 16'h0010; d_address = 16'h0030; d_wdata = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("rr c%0d d_done", c), 32'(d_done_a[0]), 32'(c == 3 || c == 11));
            chk($sformatf("rr c%0d i_done", c), 32'(i_done_a[0]), 32'(c == 7 || c == 15));
            if (c == 1) chk("rr first grant addr",  32'(m_address_a[0]), 32'h0030);
            if (c == 5) chk("rr second grant addr", 32'(m_address_a[0]), 32'h0010);
            if (c == 3) chk("rr d_rdata", 32'(d_rdata_a[0]), 32'h5A6A);
            if (c == 7) chk("rr i_data",  32'(i_data_a[0]),  32'hABCD);
        end
        i_readM = 1'b0; d_readM = 1'b0;

        // Reset in cycle 1 of BUSY_D: abandoned, then the held request restarts.
        d_readM = 1'b1; d_address = 16'h0060;
        @(posedge clk);
        @(negedge clk);
        chk("rm pre m_readM", 32'(m_readM_a[0]), 32'h1);
        chk("rm pre busy",    32'(busy_a[0]),    32'h1);
        reset = 1'b1;
        #1;
        chk("rm busy",      32'(busy_a[0]),      32'h0);
        chk("rm m_readM",   32'(m_readM_a[0]),   32'h0);
        chk("rm m_address", 32'(m_address_a[0]), 32'h0);
        chk("rm d_rdata",   32'(d_rdata_a[0]),   32'h0);
        chk("rm i_data",    32'(i_data_a[0]),    32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rm hold%0d d_done", c), 32'(d_done_a[0]), 32'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 d_readM = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("rm restart c%0d d_done", c), 32'(d_done_a[0]), 32'(c == 3));
            if (c == 1) chk("rm restart m_address", 32'(m_address_a[0]), 32'h0060);
        end
        chk("rm restart d_rdata", 32'(d_rdata_a[0]), 32'h5A3A);

        // Latency variants: done lands in cycle MEM_LATENCY+1 for 2, 1 and 5.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_readM = 1'b1; i_address = 16'h0010;
        @(posedge clk);
        #1 i_readM = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("lat2 c%0d i_done", c), 32'(i_done_a[0]), 32'(c == 3));
            chk($sformatf("lat1 c%0d i_done", c), 32'(i_done_a[1]), 32'(c == 2));
            chk($sformatf("lat5 c%0d i_done", c), 32'(i_done_a[2]), 32'(c == 6));
            if (c == 2) chk("lat1 i_data", 32'(i_data_a[1]), 32'hABCD);
            if (c == 6) chk("lat5 i_data", 32'(i_data_a[2]), 32'hABCD);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WORD_SIZE SHALL be: default 16, address and data width.
REQ-002 Parameter MEM_LATENCY SHALL be: default 2, memory cycles from issue to valid m_rdata, legal range 1..15.
REQ-003 Port clk SHALL be: input, 1, single clock, all state on rising edge.
REQ-004 Port reset SHALL be: input, 1, asynchronous active-high reset.
REQ-005 Ports SHALL be: i_readM input 1 (instruction fetch request); i_address input WORD_SIZE; i_data output WORD_SIZE; i_done output 1.
REQ-006 Ports SHALL be: d_readM input 1; d_writeM input 1; d_address input WORD_SIZE; d_wdata input WORD_SIZE; d_rdata output WORD_SIZE; d_done output 1.
REQ-007 Ports SHALL be: m_readM output 1; m_writeM output 1; m_address output WORD_SIZE; m_wdata output WORD_SIZE; m_rdata input WORD_SIZE.
REQ-008 Port busy SHALL be: output, 1, high whenever the FSM is not IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, BUSY_I, BUSY_D and DONE.
REQ-010 Requests SHALL be sampled only in IDLE; a request is pending when i_readM=1 (I) or d_readM|d_writeM=1 (D).
REQ-011 Single pending request: grant it at the edge, latch address, op and wdata, and enter BUSY_I or BUSY_D with count=MEM_LATENCY-1.
REQ-012 Both pending: grant the requester not served last (round-robin via last_grant bit); after reset last_grant=I, so the first tie goes to D.
REQ-013 In BUSY_x, m_address, m_wdata and m_readM/m_writeM SHALL be driven from the latched values and held stable for all MEM_LATENCY cycles.
REQ-014 In BUSY_x, each edge with count>0 SHALL decrement count; the edge with count==0 SHALL capture m_rdata (reads only) into i_data or d_rdata and enter DONE.
REQ-015 In DONE, exactly one of i_done/d_done SHALL be high for one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-016 The grant edge is cycle 0; done SHALL be high in cycle MEM_LATENCY+1; throughput SHALL be one access per MEM_LATENCY+2 cycles.
REQ-017 d_readM=d_writeM=1 SHALL be treated as a write.
REQ-018 A write SHALL leave d_rdata unchanged, and d_done SHALL still pulse.
REQ-019 i_data and d_rdata SHALL hold their last captured value until the next completed read of the same requester.
REQ-020 A request deasserted mid-access SHALL NOT abort it; completion and the done pulse still occur.
REQ-021 A request held through DONE SHALL be re-arbitrated in the following IDLE cycle as a new access.
REQ-022 m_readM and m_writeM SHALL be 0 in IDLE and DONE and never both high.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, count=0, last_grant=I, and all outputs (done, data, m_*, busy) to 0.
REQ-024 Reset mid-access SHALL abandon the access with no done pulse and no data capture.

Structure
REQ-025 State encoding (2-bit) and the MEM_LATENCY default SHALL live in constants.v; WORD_SIZE SHALL come from the shared constant set.
REQ-026 One sub-module SHALL implement the down-counter with load and zero flag: mem_latency_counter.
REQ-027 No combinational path SHALL run from m_rdata to any output.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- MEM_LATENCY=2; i_readM=1, i_address=0x0010, memory returns 0xABCD -> m_readM high in cycles 1-2, i_done high in cycle 3, i_data=0xABCD.
- d_writeM=1, d_address=0x0020, d_wdata=0x1234 -> m_writeM=1, m_address=0x0020, m_wdata=0x1234 held 2 cycles; d_done pulses in cycle 3; d_rdata unchanged.
- i_readM and d_readM both held high from reset release -> grant order D, I, D, I; done pulses alternate, each 4 cycles apart.
- Reset asserted in cycle 1 of BUSY_D -> outputs 0 the same cycle, no d_done; after release, the held request restarts from IDLE.
- d_readM dropped after the grant edge -> access completes, d_done pulses in cycle MEM_LATENCY+1.
- Rerun with MEM_LATENCY=1 and MEM_LATENCY=5 -> done in cycles 2 and 6 respectively.
